pong_vga_timing: RTL and testbench
==================================

Name: pong_vga_timing

Overview:
- Source end of the mono video/sync stream that the SDL/VGA display model samples once per clock.
- Generates 640x480@60 VGA timing and exposes pixel coordinates to the game video logic.
- Takes the 1-bit composite video (ball | score | paddles) back in and emits a blank-gated 9-bit rgb together with hsync and vsync, all phase-aligned.
- Replaces the ad-hoc sync path so the display sees clean, stable timing.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active low)
- VS_POL, 0, vsync active level
- CW, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_ce  in  1  pixel clock enable; all state advances only when high
- vid_in  in  1  mono video for the current (hcount, vcount), combinational from upstream
- hcount  out  CW  current pixel column, registered counter
- vcount  out  CW  current line, registered counter
- hsync  out  1  horizontal sync at HS_POL
- vsync  out  1  vertical sync at VS_POL
- hblank  out  1  horizontal blanking
- vblank  out  1  vertical blanking
- de  out  1  display enable = ~hblank & ~vblank
- rgb  out  9  {9{vid_in & de}}, registered
- frame_start  out  1  one-clk pulse marking output of pixel (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Reset (synchronous, dominates pix_ce):
  - hcount = vcount = 0; hsync = ~HS_POL; vsync = ~VS_POL.
  - hblank = vblank = 1; de = 0; rgb = 0; frame_start = 0.
- Counters, only on clk edges where pix_ce = 1:
  - hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps from V_TOTAL-1 to 0, only when hcount also wraps.
- Output stage: registered, updated on pix_ce, held otherwise. Each update decodes the pre-increment counts (h, v):
  - hblank = (h >= H_ACTIVE); vblank = (v >= V_ACTIVE).
  - hsync active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. vsync is line-granular and changes together with hsync-line boundaries at h = 0.
  - rgb = 9'h1FF iff vid_in & in-active(h, v), else 0.
- Latency: sync, blank, de and rgb lag hcount/vcount by exactly one pix_ce. Upstream computes vid_in from the current hcount/vcount with no extra delay.
- frame_start: high for exactly one clk, on the clk following the pix_ce update that registered (0,0). Never high when pix_ce has not advanced.
- pix_ce held low: everything freezes; no pulse repeats.
- pix_ce tied high: pixel rate equals clk.
- Reset mid-frame: next pix_ce after release outputs pixel (0,0) and pulses frame_start.
- vid_in is ignored during blanking; rgb is forced to 0 there.

Optional Feature:
- PONG_VGA_BORDER_EN defined:
  - rgb is additionally forced to 9'h1FF on active pixels where h = 0, h = H_ACTIVE-1, v = 0 or v = V_ACTIVE-1.
  - The border is OR'd with vid_in, for screen-alignment checks in simulation.
- Undefined: no border logic is present; rgb depends on vid_in only.

Decomposition:
- Package pong_video_pkg holds:
  - default 640x480 timing constants;
  - derived totals and sync start/end localparams;
  - counter width CW;
  - rgb width (9) and the ARGB packing constant the display wrapper uses.
- Sub-module pong_sync_axis, instantiated twice (horizontal and vertical):
  - parameters ACTIVE/FP/SYNC/BP/POL;
  - inputs clk, reset, step;
  - outputs count, wrap, blank_d, sync_d (decode of the pre-step count).
  - The horizontal instance steps on pix_ce; the vertical instance steps on pix_ce & h_wrap.

Test Plan:
- Reset then pix_ce = 1 every clk, 1 frame → hsync low for exactly 96 clks starting at the output of h = 656; line period 800 clks; vsync low for lines 490–491 (1600 clks); frame_start period 420000 clks.
- pix_ce = 1 every 2nd clk → all periods double (line 1600 clks); outputs change only after ce edges; frame_start width stays 1 clk.
- vid_in = 1 constant → rgb = 9'h1FF exactly when de = 1; 640×480 = 307200 lit pixels per frame; rgb = 0 in all blanking.
- Assert reset at h = 300, v = 200 for 3 clks → outputs take reset values on the next edge; first post-reset update is (0,0) with frame_start = 1.
- Wrap corner: h = 799, v = 524 → next counts are (0,0); h = 799, v = 100 → (0,101); no glitch on vsync at the line boundary.
- PONG_VGA_BORDER_EN with vid_in = 0 → 2·640 + 2·478 = 2236 lit pixels per frame; macro undefined → 0 lit pixels.

Source files
------------

// File: rtl/pong_video_pkg.sv
// Shared 640x480@60 VGA timing constants, counter/rgb widths and ARGB packing
// for the pong video path.
package pong_video_pkg;

   localparam int CW_DEF       = 10;
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
   localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
   localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
   localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

   localparam int              RGB_W      = 9;
   localparam logic [RGB_W-1:0] RGB_ON    = 9'h1FF;
   localparam logic [31:0]      ARGB_ALPHA = 32'hFF00_0000;

   // Display wrapper widens each 3-bit channel to 8 bits by bit replication.
   function automatic logic [31:0] argb_pack(input logic [RGB_W-1:0] rgb);
      logic [7:0] r, g, b;
      r = {rgb[8:6], rgb[8:6], rgb[8:7]};
      g = {rgb[5:3], rgb[5:3], rgb[5:4]};
      b = {rgb[2:0], rgb[2:0], rgb[2:1]};
      return ARGB_ALPHA | {8'h00, r, g, b};
   endfunction

endpackage

// File: rtl/pong_vga_timing_sync_axis.sv
// One timing axis (horizontal or vertical): wrapping position counter plus
// blank/sync decode of the count as it stands before the step.
module pong_sync_axis
   import pong_video_pkg::*;
#(
   parameter int   ACTIVE = 640,
   parameter int   FP     = 16,
   parameter int   SYNC   = 96,
   parameter int   BP     = 48,
   parameter logic POL    = 1'b0,
   parameter int   CW     = CW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          step,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          blank_d,
   output logic          sync_d
);

   localparam logic [CW-1:0] LAST    = CW'(ACTIVE + FP + SYNC + BP - 1);
   localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);
   localparam logic [CW-1:0] SYNC_S  = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] SYNC_E  = CW'(ACTIVE + FP + SYNC);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      wrap    = step & (count_q == LAST);
      if (step) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count   = count_q;
   assign blank_d = (count_q >= ACT_END);
   assign sync_d  = ((count_q >= SYNC_S) && (count_q < SYNC_E)) ? POL : ~POL;

endmodule

// File: rtl/pong_vga_timing.sv
// VGA timing source: pixel counters, registered sync/blank/rgb stage one pixel
// behind the counters. Define PONG_VGA_BORDER_EN to light a one-pixel frame border.
module pong_vga_timing
   import pong_video_pkg::*;
#(
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   H_FP     = H_FP_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BP     = H_BP_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   V_FP     = V_FP_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BP     = V_BP_DEF,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   CW       = CW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_ce,
   input  logic             vid_in,
   output logic [CW-1:0]    hcount,
   output logic [CW-1:0]    vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             hblank,
   output logic             vblank,
   output logic             de,
   output logic [RGB_W-1:0] rgb,
   output logic             frame_start
);

   logic h_wrap, v_wrap, h_blank_d, v_blank_d, h_sync_d, v_sync_d;
   logic v_step, lit_d, at_origin_q;
   logic hsync_q, vsync_q, hblank_q, vblank_q, fs_q;
   logic [RGB_W-1:0] rgb_q, rgb_d;

   assign v_step = pix_ce & h_wrap;

   pong_sync_axis #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
   ) u_h_axis (
      .clk(clk), .reset(reset), .step(pix_ce),
      .count(hcount), .wrap(h_wrap), .blank_d(h_blank_d), .sync_d(h_sync_d)
   );

   pong_sync_axis #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
   ) u_v_axis (
      .clk(clk), .reset(reset), .step(v_step),
      .count(vcount), .wrap(v_wrap), .blank_d(v_blank_d), .sync_d(v_sync_d)
   );

   always_comb begin
      lit_d = vid_in;
`ifdef PONG_VGA_BORDER_EN
      lit_d = vid_in
            | (hcount == CW'(0)) | (hcount == CW'(H_ACTIVE - 1))
            | (vcount == CW'(0)) | (vcount == CW'(V_ACTIVE - 1));
`endif
      rgb_d = (lit_d & ~h_blank_d & ~v_blank_d) ? RGB_ON : '0;
   end

   // The counters reach (0,0) only through reset or a full-frame wrap, so a
   // flag tracks that instead of a wide compare.
   always_ff @(posedge clk) begin
      if (reset) begin
         at_origin_q <= 1'b1;
         hsync_q     <= ~HS_POL;
         vsync_q     <= ~VS_POL;
         hblank_q    <= 1'b1;
         vblank_q    <= 1'b1;
         rgb_q       <= '0;
         fs_q        <= 1'b0;
      end else begin
         fs_q <= pix_ce & at_origin_q;
         if (pix_ce) begin
            at_origin_q <= h_wrap & v_wrap;
            hsync_q     <= h_sync_d;
            vsync_q     <= v_sync_d;
            hblank_q    <= h_blank_d;
            vblank_q    <= v_blank_d;
            rgb_q       <= rgb_d;
         end
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign hblank      = hblank_q;
   assign vblank      = vblank_q;
   assign de          = ~hblank_q & ~vblank_q;
   assign rgb         = rgb_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_pong_vga_timing.sv
// Self-checking bench for pong_vga_timing using a reduced raster so whole
// frames fit in a short run; a reference model feeds an expected-output queue.
module tb_pong_vga_timing;

   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 6,  VF = 2, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;
`ifdef PONG_VGA_BORDER_EN
   localparam int BORDER_LIT = 2 * HA + 2 * (VA - 2);
`else
   localparam int BORDER_LIT = 0;
`endif

   typedef struct packed {
      logic [9:0] hc;
      logic [9:0] vc;
      logic       hs, vs, hb, vb, de;
      logic [8:0] rgb;
      logic       fs;
   } obs_t;

   logic clk = 1'b0;
   logic reset, pix_ce, vid_in;
   logic [9:0] hcount, vcount;
   logic hsync, vsync, hblank, vblank, de, frame_start;
   logic [8:0] rgb;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int mh = 0, mv = 0;
   obs_t exp_cur;
   obs_t sb[$];

   always #5 clk = ~clk;

   pong_vga_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .CW(10)
   ) dut (
      .clk(clk), .reset(reset), .pix_ce(pix_ce), .vid_in(vid_in),
      .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
      .hblank(hblank), .vblank(vblank), .de(de), .rgb(rgb),
      .frame_start(frame_start)
   );

   // One clk: drive inputs on the falling edge, push the model's expectation,
   // then compare the DUT just after the rising edge.
   task automatic cycle(input logic rst, input logic ce, input logic vd);
      obs_t got, e;
      logic act, lit;
      @(negedge clk);
      reset = rst; pix_ce = ce; vid_in = vd;
      if (rst) begin
         mh = 0; mv = 0;
         exp_cur = '{hc: 10'd0, vc: 10'd0, hs: 1'b1, vs: 1'b1, hb: 1'b1, vb: 1'b1,
                     de: 1'b0, rgb: 9'd0, fs: 1'b0};
      end else if (ce) begin
         exp_cur.hb = (mh >= HA);
         exp_cur.vb = (mv >= VA);
         exp_cur.de = ~exp_cur.hb & ~exp_cur.vb;
         exp_cur.hs = !(mh >= HA + HF && mh < HA + HF + HS);
         exp_cur.vs = !(mv >= VA + VF && mv < VA + VF + VS);
         act = exp_cur.de;
         lit = vd;
`ifdef PONG_VGA_BORDER_EN
         lit = vd | (mh == 0) | (mh == HA - 1) | (mv == 0) | (mv == VA - 1);
`endif
         exp_cur.rgb = (act && lit) ? 9'h1FF : 9'h000;
         exp_cur.fs = (mh == 0 && mv == 0);
         if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else begin
            mh = mh + 1;
         end
         exp_cur.hc = 10'(mh);
         exp_cur.vc = 10'(mv);
      end else begin
         exp_cur.fs = 1'b0;
      end
      sb.push_back(exp_cur);
      @(posedge clk);
      #1;
      cyc++;
      got = '{hc: hcount, vc: vcount, hs: hsync, vs: vsync, hb: hblank, vb: vblank,
              de: de, rgb: rgb, fs: frame_start};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL scoreboard cyc=%0d got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b de=%b rgb=%h fs=%b exp h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b de=%b rgb=%h fs=%b",
                  cyc, got.hc, got.vc, got.hs, got.vs, got.hb, got.vb, got.de, got.rgb, got.fs,
                  e.hc, e.vc, e.hs, e.vs, e.hb, e.vb, e.de, e.rgb, e.fs);
      end
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
   endtask

   task automatic run_until(input int h, input int v, input logic vd);
      int n = 0;
      while (!(hcount == 10'(h) && vcount == 10'(v)) && n < 2 * FRAME) begin
         cycle(1'b0, 1'b1, vd);
         n++;
      end
      total++;
      if (n >= 2 * FRAME) begin
         bad++;
         $display("FAIL run_until timeout got h=%0d v=%0d want h=%0d v=%0d", hcount, vcount, h, v);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; pix_ce = 1'b0; vid_in = 1'b0;
      do_reset();
      total++;
      if ({hsync, vsync, hblank, vblank, de, rgb, frame_start} !== {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0}) begin
         bad++;
         $display("FAIL reset_outputs got=%b exp=%b", {hsync, vsync, hblank, vblank, de, rgb, frame_start},
                  {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0});
      end
   endtask

   task automatic test_full_rate();
      int last_fs = -1, last_hfall = -1, hfall = 0, vfall = 0;
      logic phs = 1'b1, pvs = 1'b1;
      do_reset();
      for (int i = 0; i < 2 * FRAME + 10; i++) begin
         cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
         if (frame_start) begin
            if (last_fs >= 0) begin
               total++;
               if (cyc - last_fs !== FRAME) begin
                  bad++;
                  $display("FAIL frame_period got=%0d exp=%0d", cyc - last_fs, FRAME);
               end
            end
            last_fs = cyc;
         end
         if (phs && !hsync) begin
            hfall = cyc;
            total++;
            if (hcount !== 10'(HA + HF + 1)) begin
               bad++;
               $display("FAIL hsync_start got_h=%0d exp_h=%0d", hcount, HA + HF + 1);
            end
            if (last_hfall >= 0) begin
               total++;
               if (cyc - last_hfall !== HT) begin
                  bad++;
                  $display("FAIL line_period got=%0d exp=%0d", cyc - last_hfall, HT);
               end
            end
            last_hfall = cyc;
         end
         if (!phs && hsync) begin
            total++;
            if (cyc - hfall !== HS) begin
               bad++;
               $display("FAIL hsync_width got=%0d exp=%0d", cyc - hfall, HS);
            end
         end
         if (pvs && !vsync) begin
            vfall = cyc;
            total++;
            if (vcount !== 10'(VA + VF) || hcount !== 10'd1) begin
               bad++;
               $display("FAIL vsync_start got h=%0d v=%0d exp h=1 v=%0d", hcount, vcount, VA + VF);
            end
         end
         if (!pvs && vsync) begin
            total++;
            if (cyc - vfall !== VS * HT) begin
               bad++;
               $display("FAIL vsync_width got=%0d exp=%0d", cyc - vfall, VS * HT);
            end
         end
         phs = hsync;
         pvs = vsync;
      end
   endtask

   task automatic test_half_rate();
      int last_hfall = -1, n_fs = 0;
      logic phs = 1'b1, pfs = 1'b0;
      logic [9:0] ph;
      do_reset();
      for (int i = 0; i < 8 * HT; i++) begin
         ph = hcount;
         cycle(1'b0, 1'(i % 2 == 0), 1'b1);
         if (i % 2 == 1) begin
            total++;
            if (hcount !== ph) begin
               bad++;
               $display("FAIL half_hold got_h=%0d exp_h=%0d", hcount, ph);
            end
         end
         if (frame_start) n_fs++;
         if (pfs && frame_start) begin
            total++; bad++;
            $display("FAIL fs_width got=2+ exp=1 at cyc=%0d", cyc);
         end
         if (phs && !hsync) begin
            if (last_hfall >= 0) begin
               total++;
               if (cyc - last_hfall !== 2 * HT) begin
                  bad++;
                  $display("FAIL half_line_period got=%0d exp=%0d", cyc - last_hfall, 2 * HT);
               end
            end
            last_hfall = cyc;
         end
         phs = hsync;
         pfs = frame_start;
      end
      total++;
      if (n_fs !== 1) begin
         bad++;
         $display("FAIL half_fs_count got=%0d exp=1", n_fs);
      end
   endtask

   task automatic test_lit(input logic vd, input int want, input string nm);
      int lit = 0, blank_lit = 0;
      do_reset();
      for (int i = 0; i < FRAME; i++) begin
         cycle(1'b0, 1'b1, vd);
         if (rgb == 9'h1FF) lit++;
         if (rgb != 9'h000 && !de) blank_lit++;
      end
      total++;
      if (lit !== want) begin
         bad++;
         $display("FAIL %s_count got=%0d exp=%0d", nm, lit, want);
      end
      total++;
      if (blank_lit !== 0) begin
         bad++;
         $display("FAIL %s_blank_rgb got=%0d exp=0", nm, blank_lit);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      run_until(10, 3, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
      total++;
      if ({hcount, vcount, hsync, hblank, rgb, frame_start} !== {10'd0, 10'd0, 1'b1, 1'b1, 9'h000, 1'b0}) begin
         bad++;
         $display("FAIL reset_mid_hold got h=%0d v=%0d hs=%b hb=%b rgb=%h fs=%b exp zeros/idle",
                  hcount, vcount, hsync, hblank, rgb, frame_start);
      end
      cycle(1'b0, 1'b1, 1'b1);
      total++;
      if ({frame_start, de, rgb, hcount, vcount} !== {1'b1, 1'b1, 9'h1FF, 10'd1, 10'd0}) begin
         bad++;
         $display("FAIL reset_mid_first got fs=%b de=%b rgb=%h h=%0d v=%0d exp fs=1 de=1 rgb=1ff h=1 v=0",
                  frame_start, de, rgb, hcount, vcount);
      end
   endtask

   task automatic test_wrap();
      logic pvs;
      do_reset();
      run_until(HT - 1, 3, 1'b0);
      pvs = vsync;
      cycle(1'b0, 1'b1, 1'b0);
      total++;
      if ({hcount, vcount, vsync} !== {10'd0, 10'd4, pvs}) begin
         bad++;
         $display("FAIL wrap_line got h=%0d v=%0d vs=%b exp h=0 v=4 vs=%b", hcount, vcount, vsync, pvs);
      end
      run_until(HT - 1, VT - 1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      total++;
      if ({hcount, vcount, frame_start} !== {10'd0, 10'd0, 1'b0}) begin
         bad++;
         $display("FAIL wrap_frame got h=%0d v=%0d fs=%b exp h=0 v=0 fs=0", hcount, vcount, frame_start);
      end
      cycle(1'b0, 1'b1, 1'b0);
      total++;
      if (frame_start !== 1'b1) begin
         bad++;
         $display("FAIL wrap_fs got=%b exp=1", frame_start);
      end
   endtask

   task automatic test_hold();
      int n_fs = 0;
      do_reset();
      cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
         if (frame_start) n_fs++;
      end
      total++;
      if (n_fs !== 0 || hcount !== 10'd1) begin
         bad++;
         $display("FAIL hold got fs_pulses=%0d h=%0d exp fs_pulses=0 h=1", n_fs, hcount);
      end
   endtask

   initial begin
      test_reset();
      test_full_rate();
      test_half_rate();
      test_lit(1'b1, HA * VA, "lit_vid1");
      test_lit(1'b0, BORDER_LIT, "lit_border");
      test_reset_mid();
      test_wrap();
      test_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
